// File: rtl/sa33_feeder_pkg.sv
// sa33_pkg: shared sizes, FSM states and window addressing for the 3x3/4x4 systolic feeder
package sa33_pkg;

    localparam int DW    = 8;
    localparam int KS    = 3;
    localparam int IS    = 4;
    localparam int OS    = IS - KS + 1;
    localparam int NL    = OS * OS;
    localparam int NK    = KS * KS;
    localparam int NP    = IS * IS;
    localparam int NSTEP = NK + NL - 1;

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_A = 2'd1,
        FEED   = 2'd2
    } state_t;

    // Pixel address seen by output lane `lane` at kernel element `k`
    function automatic logic [3:0] win_addr(input int lane, input logic [3:0] k);
        int kk;
        kk = int'(k);
        return 4'(((lane / OS) + kk / KS) * IS + (lane % OS) + kk % KS);
    endfunction

endpackage

// File: rtl/sa33_feeder_skew_lane.sv
// sa33_skew_lane: decodes the step counter into one lane's skewed operand pair
module sa33_skew_lane
    import sa33_pkg::*;
#(
    parameter int J = 0
) (
    input  logic          i_en,
    input  logic [3:0]    i_t,
    input  logic [DW-1:0] i_w [NK],
    input  logic [DW-1:0] i_p [NP],
    output logic          o_vld,
    output logic [DW-1:0] o_act,
    output logic [DW-1:0] o_wgt
);

    logic [3:0] w_k;
    logic [3:0] w_ki;
    logic [3:0] w_addr;

    // Lane j runs j steps behind lane 0; indices are forced to 0 outside the window
    always_comb begin
        w_k    = i_t - 4'(J);
        o_vld  = i_en && (i_t >= 4'(J)) && (w_k < 4'(NK));
        w_ki   = o_vld ? w_k : 4'd0;
        w_addr = o_vld ? win_addr(J, w_k) : 4'd0;
        o_act  = o_vld ? i_p[w_addr] : '0;
        o_wgt  = o_vld ? i_w[w_ki] : '0;
    end

endmodule

// File: rtl/sa33_feeder.sv
// sa33_feeder: buffers a 9-weight kernel and 16-pixel tile, then feeds four skewed PE lanes.
// Optional SA33_FEEDER_KEEP_W_EN adds keep_w to reuse the loaded kernel for the next tile.
module sa33_feeder
    import sa33_pkg::*;
#(
    parameter int DW = 8,
    parameter int KS = 3,
    parameter int IS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic [NL-1:0]    lane_vld,
    output logic [NL*DW-1:0] act,
`ifdef SA33_FEEDER_KEEP_W_EN
    output logic [NL*DW-1:0] wgt,
    input  logic             keep_w
`else
    output logic [NL*DW-1:0] wgt
`endif
);

    if (KS != 3 || IS != 4) begin : g_bad_cfg
        $error("sa33_feeder: KS and IS are fixed at 3 and 4");
    end

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    r_t;
    logic          r_wl;
    logic [DW-1:0] r_w [NK];
    logic [DW-1:0] r_p [NP];
    logic          w_xfer;
    logic          w_step;
    logic          w_w_done;
    logic          w_a_done;
    logic          w_keep;

`ifdef SA33_FEEDER_KEEP_W_EN
    assign w_keep = keep_w && r_wl;
`else
    assign w_keep = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= LOAD_W;
        else
            r_state <= w_next;
    end

    // Handshake decode and next-state selection
    always_comb begin
        in_ready  = r_state != FEED;
        out_valid = r_state == FEED;
        out_last  = out_valid && (r_t == 4'(NSTEP - 1));
        w_xfer    = in_valid && in_ready;
        w_step    = out_valid && out_ready;
        w_w_done  = (r_state == LOAD_W) && w_xfer && (r_cnt == 4'(NK - 1));
        w_a_done  = (r_state == LOAD_A) && w_xfer && (r_cnt == 4'(NP - 1));
        w_next    = w_w_done ? LOAD_A :
                    w_a_done ? FEED :
                    (w_step && out_last) ? (w_keep ? LOAD_A : LOAD_W) : r_state;
    end

    // Byte/step counters and operand buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_t   <= '0;
            r_wl  <= 1'b0;
            for (int i = 0; i < NK; i++) r_w[i] <= '0;
            for (int i = 0; i < NP; i++) r_p[i] <= '0;
        end else begin
            if (w_xfer)
                r_cnt <= (w_w_done || w_a_done) ? 4'd0 : r_cnt + 4'd1;
            if (w_xfer && r_state == LOAD_W)
                r_w[r_cnt] <= in_data;
            if (w_xfer && r_state == LOAD_A)
                r_p[r_cnt] <= in_data;
            if (w_w_done)
                r_wl <= 1'b1;
            if (w_step)
                r_t <= out_last ? 4'd0 : r_t + 4'd1;
        end
    end

    for (genvar j = 0; j < NL; j++) begin : g_lane
        sa33_skew_lane #(.J(j)) u_lane (
            .i_en  (out_valid),
            .i_t   (r_t),
            .i_w   (r_w),
            .i_p   (r_p),
            .o_vld (lane_vld[j]),
            .o_act (act[j*DW +: DW]),
            .o_wgt (wgt[j*DW +: DW])
        );
    end

endmodule

// File: doc/sa33_feeder.md
Name: sa33_feeder

Overview:
- Producer-side companion to the 3x3-kernel / 4x4-tile / 2x2-output systolic convolution array.
- Accepts one byte stream containing a kernel followed by a pixel tile, over a valid/ready handshake, and buffers both.
- Then streams operands into the array's four output-stationary PEs: one lane per output pixel, with a diagonal skew of one cycle per lane.
- Sits between the memory/DMA byte stream and the array.

Parameters:
- DW, 8, width of pixels and weights.
- KS, 3, kernel side. Fixed; elaboration error if changed.
- IS, 4, tile side. Fixed; OS = IS-KS+1 = 2, NL = OS*OS = 4 lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_data  in  DW  weight or pixel byte.
- in_ready  out  1  feeder accepts a byte this cycle.
- out_ready  in  1  array accepts the current operand step.
- out_valid  out  1  operand step valid.
- out_last  out  1  final step (t=11) of the current tile.
- lane_vld  out  NL  per-lane operand valid; bit j is lane j.
- act  out  NL*DW  lane j activation at bits [j*DW +: DW].
- wgt  out  NL*DW  lane j weight at bits [j*DW +: DW].

Behaviour:
- Reset (asynchronous, active-high):
  - state = LOAD_W; byte counter and step counter t = 0.
  - All buffers = 0; w_loaded = 0.
  - out_valid, out_last, lane_vld, act, wgt = 0.
  - in_ready = 1 once rst deasserts.
- Reset asserted mid-operation aborts immediately. No partial output; the next frame restarts at weight 0.
- Byte transfer occurs when in_valid && in_ready.
- State LOAD_W:
  - in_ready = 1.
  - Bytes fill w[0..8], row-major: k = kr*3 + kc.
  - After the 9th transfer: w_loaded = 1, go to LOAD_A.
- State LOAD_A:
  - in_ready = 1.
  - Bytes fill p[0..15], row-major: r*4 + c.
  - After the 16th transfer: go to FEED with t = 0.
- Gaps in in_valid stall loading without loss.
- State FEED:
  - in_ready = 0; out_valid = 1.
  - t advances only when out_ready = 1. With out_ready = 0, all outputs hold stable.
  - Lane j = output pixel (oy, ox) = (j/2, j%2).
  - Element index k = t - j.
  - lane_vld[j] = 1 iff 0 <= k <= 8.
  - When valid: act lane j = p[(oy+k/3)*4 + ox + k%3] and wgt lane j = w[k]. Otherwise both are 0.
  - Total 12 steps (t = 0..11).
  - out_last = 1 at t = 11. A handshake there returns to LOAD_W with t = 0.
- act, wgt, lane_vld and out_* are combinational decodes of registered state, t and buffers.
  - Zero latency from state to outputs.
  - Buffer write to first visible output: 1 cycle.
- No arithmetic is performed; widths pass through unchanged.
- Counters never wrap mid-phase; terminal counts are explicit compares.

Optional Feature:
- Macro: SA33_FEEDER_KEEP_W_EN.
- Defined:
  - Adds input port keep_w (1 bit).
  - FEED exit goes to LOAD_A instead of LOAD_W when keep_w = 1 and w_loaded = 1, both sampled on the final FEED handshake.
  - The kernel is reused and the next byte is pixel 0.
  - Reset still clears w_loaded, forcing a weight load first.
- Undefined: no keep_w port; every frame is 9 weights followed by 16 pixels.

Decomposition:
- Package sa33_pkg holds:
  - DW, KS, IS, OS, NL, NSTEP = 12 localparams.
  - State enum LOAD_W / LOAD_A / FEED, 2-bit.
  - Window-index function (lane, k) -> pixel address.
- One natural sub-module, sa33_skew_lane: per-lane combinational decode of t and j into lane_vld/act/wgt. Instantiated NL times.

Test Plan:
- Basic frame: weights 1..9 and pixels 1..16 back-to-back, out_ready = 1.
  - t=0: lane_vld = 0001; act0 = 1, wgt0 = 1.
  - t=2: act0 = 3 / wgt0 = 3; act2 = 5 / wgt2 = 1.
  - t=11: lane_vld = 1000, act3 = 16, wgt3 = 9, out_last = 1.
- Dot-product check on the same frame: scoreboard sums act*wgt per lane.
  - Required: lane0 = 348, lane1 = 393, lane2 = 528, lane3 = 573.
- Backpressure: out_ready low for 3 cycles at t=5 → outputs frozen at their t=5 values; total FEED handshakes still 12.
- Input gaps: in_valid toggled 1/0 randomly during load → same outputs as the basic frame; in_ready = 0 throughout FEED.
- Reset at t=6 → next cycle out_valid = 0, in_ready = 1, lane_vld = 0. A fresh 25-byte frame produces the correct result.
- With SA33_FEEDER_KEEP_W_EN, keep_w = 1: second frame of 16 pixels (all 2s) → lane0 sum = 90, using the retained weights 1..9.
